// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared state encoding, default windows and helpers for the PPM frame delimiter
// Purpose: one place for the FSM encoding, the default pulse/SOF/EOF windows,
//          the in-frame idle timeout and the window-compare helper.
// Ports:   none (package).
package ppm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam int PPM_CNT_W     = 8;
  localparam int PPM_PULSE_MIN = 4;
  localparam int PPM_PULSE_MAX = 12;
  localparam int PPM_SOF_MIN   = 20;
  localparam int PPM_SOF_MAX   = 28;
  localparam int PPM_EOF_MIN   = 36;
  localparam int PPM_EOF_MAX   = 44;
  localparam int PPM_IDLE_MAX  = 40;

  // Inclusive window compare on a measured run length.
  function automatic logic in_win(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ppm_frame_delim_if.sv
// rtl/ppm_frame_delim_if.sv - line input and frame-event outputs of the PPM frame delimiter
// Purpose: bundles the PPM line, enable and the delimiter strobes.
// Ports:   slave  - delimiter side (Din/en in, strobes/pulse_gap/frame_active out)
//          master - line driver / consumer side (mirror of slave)
interface ppm_frame_delim_if #(
  parameter int CNT_W = 8
);
  logic             Din;
  logic             en;
  logic             sof_rcv_out;
  logic             pulse_rcv_out;
  logic [CNT_W-1:0] pulse_gap;
  logic             eof_rcv_out;
  logic             err_out;
  logic             frame_active;

  modport slave (
    input  Din, en,
    output sof_rcv_out, pulse_rcv_out, pulse_gap, eof_rcv_out, err_out, frame_active
  );

  modport master (
    output Din, en,
    input  sof_rcv_out, pulse_rcv_out, pulse_gap, eof_rcv_out, err_out, frame_active
  );
endinterface

// File: rtl/ppm_run_cnt.sv
// rtl/ppm_run_cnt.sv - saturating run-length counter with clear
// Purpose: counts consecutive samples of one line level.
// Ports:   clk16, rst_n - clock, async active-low reset
//          zero  - force count to 0 (highest priority)
//          start - this sample begins a new run (count becomes 1)
//          inc   - this sample continues the run (+1, saturating)
//          cnt   - current run length
module ppm_run_cnt #(
  parameter int W = 8
) (
  input  logic         clk16,
  input  logic         rst_n,
  input  logic         zero,
  input  logic         start,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zero) begin
      cnt_d = '0;
    end else if (start) begin
      // The edge sample itself is the first sample of the run.
      cnt_d = W'(1);
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ppm_frame_delim.sv
// rtl/ppm_frame_delim.sv - PPM frame delimiter: SOF / data pulse / EOF / framing-error detection
// Purpose: measures low widths of the oversampled PPM line and classifies each
//          one on the rising edge; times out long in-frame idle.
// Ports:   clk16 - oversampling clock
//          rst_n - async active-low reset
//          bus   - slave modport: Din, en in; sof/pulse/eof/err strobes,
//                  pulse_gap and frame_active out
module ppm_frame_delim
  import ppm_pkg::*;
#(
  parameter int CNT_W     = PPM_CNT_W,
  parameter int PULSE_MIN = PPM_PULSE_MIN,
  parameter int PULSE_MAX = PPM_PULSE_MAX,
  parameter int SOF_MIN   = PPM_SOF_MIN,
  parameter int SOF_MAX   = PPM_SOF_MAX,
  parameter int EOF_MIN   = PPM_EOF_MIN,
  parameter int EOF_MAX   = PPM_EOF_MAX,
  parameter int IDLE_MAX  = PPM_IDLE_MAX
) (
  input  logic              clk16,
  input  logic              rst_n,
  ppm_frame_delim_if.slave  bus
);

  if (PULSE_MAX >= SOF_MIN) begin : g_chk_pulse_sof
    $error("PULSE_MAX must be below SOF_MIN");
  end
  if (SOF_MAX >= EOF_MIN) begin : g_chk_sof_eof
    $error("SOF_MAX must be below EOF_MIN");
  end
  if ((EOF_MAX >= (2**CNT_W) - 1) || (IDLE_MAX >= (2**CNT_W) - 1)) begin : g_chk_cnt_w
    $error("EOF_MAX and IDLE_MAX must be below the counter saturation value");
  end

  logic             din_q, din_d;
  logic             din_qq, din_qq_d;
  logic             armed_q, armed_d;
  state_t           state_q, state_d;
  logic             sof_q, sof_d;
  logic             pulse_q, pulse_d;
  logic             eof_q, eof_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] gap_lat_q, gap_lat_d;
  logic [CNT_W-1:0] pulse_gap_q, pulse_gap_d;
  logic [CNT_W-1:0] lo_cnt, hi_cnt;
  logic             rise, fall;
  int               lo_w;

  assign rise = din_q & ~din_qq;
  assign fall = ~din_q & din_qq;
  assign lo_w = int'(lo_cnt);

  ppm_run_cnt #(.W(CNT_W)) u_lo_cnt (
    .clk16 (clk16),
    .rst_n (rst_n),
    .zero  (~bus.en),
    .start (fall),
    .inc   (~din_q),
    .cnt   (lo_cnt)
  );

  ppm_run_cnt #(.W(CNT_W)) u_hi_cnt (
    .clk16 (clk16),
    .rst_n (rst_n),
    .zero  (~bus.en),
    .start (rise),
    .inc   (din_q),
    .cnt   (hi_cnt)
  );

  always_comb begin
    din_d       = bus.Din;
    din_qq_d    = din_q;
    armed_d     = armed_q;
    state_d     = state_q;
    sof_d       = 1'b0;
    pulse_d     = 1'b0;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    gap_lat_d   = gap_lat_q;
    pulse_gap_d = pulse_gap_q;

    if (!bus.en) begin
      // armed_q only sets on a falling edge seen while enabled, so a low run
      // already in progress when en rises is never classified.
      armed_d   = 1'b0;
      gap_lat_d = '0;
      state_d   = ST_IDLE;
    end else begin
      if (fall) begin
        armed_d   = 1'b1;
        gap_lat_d = hi_cnt;
      end
      if (rise && armed_q) begin
        case (state_q)
          ST_IDLE: begin
            if (in_win(lo_w, SOF_MIN, SOF_MAX)) begin
              sof_d   = 1'b1;
              state_d = ST_FRAME;
            end
          end
          ST_FRAME: begin
            if (in_win(lo_w, PULSE_MIN, PULSE_MAX)) begin
              pulse_d     = 1'b1;
              pulse_gap_d = gap_lat_q;
            end else if (in_win(lo_w, EOF_MIN, EOF_MAX)) begin
              eof_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end else if ((state_q == ST_FRAME) && din_q && !rise &&
                   (hi_cnt > CNT_W'(IDLE_MAX))) begin
        // Leaving FRAME makes this fire only once per over-long idle run.
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      din_q       <= 1'b1;
      din_qq      <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      sof_q       <= 1'b0;
      pulse_q     <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      gap_lat_q   <= '0;
      pulse_gap_q <= '0;
    end else begin
      din_q       <= din_d;
      din_qq      <= din_qq_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      sof_q       <= sof_d;
      pulse_q     <= pulse_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      gap_lat_q   <= gap_lat_d;
      pulse_gap_q <= pulse_gap_d;
    end
  end

  assign bus.sof_rcv_out   = sof_q;
  assign bus.pulse_rcv_out = pulse_q;
  assign bus.eof_rcv_out   = eof_q;
  assign bus.err_out       = err_q;
  assign bus.pulse_gap     = pulse_gap_q;
  // state_q updates on the same edge as the strobes, so it is already aligned.
  assign bus.frame_active  = (state_q == ST_FRAME);

endmodule
